// File: rtl/bit_seq_pkg.sv
// Shared types and helpers for the bit-serial program/bit-cycle sequencer.
package bit_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  localparam int DATA_W_DEF = 8;

  // Next bit index within a serial word, wrapping at the word length.
  function automatic int bit_wrap_inc(input int cnt, input int data_w);
    return (cnt == data_w - 1) ? 0 : cnt + 1;
  endfunction

endpackage

// File: rtl/bit_sequencer_rise_detect.sv
// Registered rising-edge detector: o_rise is high for the cycle in which
// i_sig is 1 and was 0 on the previous clock edge.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/bit_sequencer.sv
// Program counter and bit-cycle sequencer for the bit-serial processor:
// free-run, single-step and halt-at-end-of-program control.
module bit_sequencer
  import bit_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = $clog2(DATA_W),
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_loop,
  input  logic             i_pcincr,
  input  logic             i_count_rst,
  output logic [PC_W-1:0]  o_pc,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_cycle_en,
  output logic             o_halt,
  output logic             o_word_end
);

  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_bit_count;
  logic             w_step_rise;
  logic             w_cycle_en;
  logic             w_last_instr;

  rise_detect u_step_rise (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_step),
    .o_rise (w_step_rise)
  );

  assign w_last_instr = (r_pc == LAST_PC);

  // Mode changes win over execution: a cycle that leaves RUN/STEP is not
  // executed, so a step edge arriving with a mode change is discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_cycle_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_run) w_state_nxt = i_step_mode ? STEP : RUN;
      end
      RUN: begin
        if (!i_run)           w_state_nxt = IDLE;
        else if (i_step_mode) w_state_nxt = STEP;
        else                  w_cycle_en  = 1'b1;
      end
      STEP: begin
        if (!i_run)            w_state_nxt = IDLE;
        else if (!i_step_mode) w_state_nxt = RUN;
        else                   w_cycle_en  = w_step_rise;
      end
      HALT: w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
    if (w_cycle_en && i_pcincr && w_last_instr && !i_loop) w_state_nxt = HALT;
    if (i_rst) w_cycle_en = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_count <= '0;
    end else if (w_cycle_en) begin
      if (i_pcincr || i_count_rst) r_bit_count <= '0;
      else r_bit_count <= CNT_W'(bit_wrap_inc(int'(r_bit_count), DATA_W));
    end
  end

  // At the last instruction without looping the PC holds; the FSM halts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (w_cycle_en && i_pcincr) begin
      if (!w_last_instr) r_pc <= r_pc + 1'b1;
      else if (i_loop)   r_pc <= '0;
    end
  end

  assign o_pc        = r_pc;
  assign o_bit_count = r_bit_count;
  assign o_cycle_en  = w_cycle_en;
  assign o_halt      = (r_state == HALT);
  assign o_word_end  = w_cycle_en & (r_bit_count == LAST_BIT);

endmodule

// File: tb/tb_bit_sequencer.sv
// Directed testbench for bit_sequencer (DATA_W=8, PC_W=4, PROG_LEN=4).
module tb_bit_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst, i_run, i_step_mode, i_step, i_loop, i_pcincr, i_count_rst;
  logic [3:0] o_pc;
  logic [2:0] o_bit_count;
  logic       o_cycle_en, o_halt, o_word_end;

  int checks = 0;
  int errors = 0;

  bit_sequencer #(.DATA_W(8), .PC_W(4), .PROG_LEN(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (i_run),
    .i_step_mode (i_step_mode),
    .i_step      (i_step),
    .i_loop      (i_loop),
    .i_pcincr    (i_pcincr),
    .i_count_rst (i_count_rst),
    .o_pc        (o_pc),
    .o_bit_count (o_bit_count),
    .o_cycle_en  (o_cycle_en),
    .o_halt      (o_halt),
    .o_word_end  (o_word_end)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int bc,
                         input int en, input int halt, input int we);
    #1;
    chk({tag, ".pc"},   int'(o_pc), pc);
    chk({tag, ".bc"},   int'(o_bit_count), bc);
    chk({tag, ".en"},   int'(o_cycle_en), en);
    chk({tag, ".halt"}, int'(o_halt), halt);
    chk({tag, ".we"},   int'(o_word_end), we);
  endtask

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
    i_loop = 1'b0; i_pcincr = 1'b0; i_count_rst = 1'b0;
    cyc(2);
    chk_all("reset", 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    cyc();
    chk_all("idle", 0, 0, 0, 0, 0);

    // Free run, decoder idle: count 0..7,0,1
    i_run = 1'b1;
    chk_all("idle_run_req", 0, 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("run%0d", i), 0, i % 8, 1, 0, (i % 8 == 7) ? 1 : 0);
      cyc();
    end

    // pcincr at word end
    cyc(5);
    chk_all("w1_end", 0, 7, 1, 0, 1);
    i_pcincr = 1'b1;
    cyc();
    i_pcincr = 1'b0;
    chk_all("w1_next", 1, 0, 1, 0, 0);
    cyc(7);
    chk_all("w2_end", 1, 7, 1, 0, 1);
    i_pcincr = 1'b1;
    cyc();
    i_pcincr = 1'b0;
    chk_all("w2_next", 2, 0, 1, 0, 0);

    // Simultaneous pcincr + count_rst, then count_rst alone
    cyc(3);
    chk_all("pre_both", 2, 3, 1, 0, 0);
    i_pcincr = 1'b1; i_count_rst = 1'b1;
    cyc();
    i_pcincr = 1'b0; i_count_rst = 1'b0;
    chk_all("both", 3, 0, 1, 0, 0);
    cyc(2);
    i_count_rst = 1'b1;
    cyc();
    i_count_rst = 1'b0;
    chk_all("cnt_rst", 3, 0, 1, 0, 0);

    // Looping at last instruction, then halt without loop
    i_loop = 1'b1; i_pcincr = 1'b1;
    cyc();
    chk_all("loop_wrap", 0, 0, 1, 0, 0);
    cyc(3);
    chk_all("loop_at3", 3, 0, 1, 0, 0);
    i_loop = 1'b0;
    cyc();
    chk_all("halt", 3, 0, 0, 1, 0);
    i_run = 1'b0;
    cyc(2);
    i_run = 1'b1;
    cyc(2);
    chk_all("halt_sticky", 3, 0, 0, 1, 0);
    i_rst = 1'b1;
    cyc();
    chk_all("halt_rst", 0, 0, 0, 0, 0);
    i_rst = 1'b0; i_pcincr = 1'b0;

    // Single step: held step gives one cycle, pcincr between steps ignored
    i_step_mode = 1'b1;
    cyc();
    chk_all("step_entry", 0, 0, 0, 0, 0);
    i_step = 1'b1;
    chk_all("step_edge0", 0, 0, 1, 0, 0);
    cyc();
    i_pcincr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("step_hold%0d", i), 0, 1, 0, 0, 0);
      cyc();
    end
    i_step = 1'b0;
    cyc();
    for (int p = 0; p < 3; p++) begin
      i_pcincr = 1'b0; i_step = 1'b1;
      chk_all($sformatf("pulse%0d_en", p), 0, p + 1, 1, 0, 0);
      cyc();
      i_step = 1'b0; i_pcincr = 1'b1;
      chk_all($sformatf("pulse%0d_gap", p), 0, p + 2, 0, 0, 0);
      cyc();
    end
    i_pcincr = 1'b0;
    chk_all("step_done", 0, 4, 0, 0, 0);

    // Step edge coinciding with mode change is discarded
    i_step = 1'b1; i_step_mode = 1'b0;
    chk_all("mode_edge", 0, 4, 0, 0, 0);
    cyc();
    i_step = 1'b0;
    chk_all("mode_run", 0, 4, 1, 0, 0);

    // Pause freezes counters; resume continues
    i_pcincr = 1'b1;
    cyc(2);
    i_pcincr = 1'b0;
    cyc(5);
    chk_all("pre_pause", 2, 5, 1, 0, 0);
    i_run = 1'b0; i_pcincr = 1'b1;
    chk_all("pause_en", 2, 5, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk_all($sformatf("pause%0d", i), 2, 5, 0, 0, 0);
    end
    i_run = 1'b1; i_pcincr = 1'b0;
    cyc();
    chk_all("resume", 2, 5, 1, 0, 0);
    cyc();
    chk_all("resume_inc", 2, 6, 1, 0, 0);

    // Reset mid-word returns to IDLE
    i_rst = 1'b1;
    cyc();
    chk_all("midrst", 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    chk_all("midrst_idle", 0, 0, 0, 0, 0);
    cyc();
    chk_all("midrst_run", 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
